mmio_uart_tx: RTL

- Memory-mapped UART transmitter peripheral on the core's single-cycle data bus, sitting beside the LED register and data RAM.
- Consumes data-bus writes and serialises bytes onto an 8N1 TX line. Provides a boot-visible console for the minimal RISC-V system.
- Decodes its own address window and returns read data combinationally, so the top-level read mux ORs or selects it like the LED register.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/mmio_uart_tx_if.sv | 30 +++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, FSM encoding, reset divider.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Clocks per bit after reset, clamped into the 16-bit register.
    function automatic logic [15:0] default_div(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        int unsigned d;
        d = clk_hz / baud;
        if (d == 0)
            d = 1;
        if (d > 65535)
            d = 65535;
        return d[15:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Single-cycle data-bus port as seen by the UART transmitter.
// The core drives the request side; the peripheral returns read data.
interface mmio_uart_tx_if;

    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_we,
        output data_be,
        output data_addr,
        output data_wdata,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_we,
        input  data_be,
        input  data_addr,
        input  data_wdata,
        output data_rdata
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra-bit pointers; full/empty from pointer compare.
// Push when full and pop when empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + ONE;
            if (do_pop)
                rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers,
// baud counter and frame FSM around a small TX FIFO.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0100,
    parameter int unsigned CLK_HZ     = 125000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    mmio_uart_tx_if.slave bus,
    output logic uart_txd,
    output logic tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = default_div(CLK_HZ, BAUD);

    logic        sel;
    logic [1:0]  off;
    logic        wr;
    logic        wr_tx;
    logic        ovf;
    logic        ovf_set;
    logic        ovf_clr;
    logic [15:0] baud_div;
    logic [15:0] div_eff;
    logic [15:0] reload;
    logic [15:0] cnt;
    logic        bit_end;
    logic [1:0]  state;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        pop;
    logic        unused_bits;

    assign sel   = bus.data_addr[31:4] == BASE_ADDR[31:4];
    assign off   = bus.data_addr[3:2];
    assign wr    = bus.data_req & bus.data_we & sel;
    assign wr_tx = wr & (off == REG_TXDATA) & bus.data_be[0];

    // Full is the pre-edge value, so a same-cycle pop never rescues a push.
    assign ovf_set = wr_tx & fifo_full;
    assign ovf_clr = wr & (off == REG_STATUS) & bus.data_be[0] &
                     bus.data_wdata[ST_OVF];

    assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign reload  = div_eff - 16'd1;
    assign bit_end = (cnt == 16'd0);

    assign pop = ~fifo_empty &
                 ((state == S_IDLE) | ((state == S_STOP) & bit_end));

    assign tx_busy = (state != S_IDLE) | ~fifo_empty;

    assign unused_bits = &{1'b0, bus.data_wdata[31:16],
                           bus.data_addr[1:0], bus.data_be[3:2]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (pop),
        .wdata (bus.data_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div <= DIV_RST;
        end else if (wr && off == REG_BAUD_DIV) begin
            if (bus.data_be[0])
                baud_div[7:0] <= bus.data_wdata[7:0];
            if (bus.data_be[1])
                baud_div[15:8] <= bus.data_wdata[15:8];
        end
    end

    // uart_txd is loaded with the level of the state being entered,
    // so the pin changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            uart_txd <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    uart_txd <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_rdata;
                        state    <= S_START;
                        uart_txd <= 1'b0;
                        cnt      <= reload;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        idx      <= 3'd0;
                        uart_txd <= shift[0];
                        cnt      <= reload;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        cnt   <= reload;
                        if (idx == 3'd7) begin
                            state    <= S_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            idx      <= idx + 3'd1;
                            uart_txd <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            shift    <= fifo_rdata;
                            state    <= S_START;
                            uart_txd <= 1'b0;
                            cnt      <= reload;
                        end else begin
                            state    <= S_IDLE;
                            uart_txd <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        bus.data_rdata = '0;
        if (bus.data_req && sel) begin
            unique case (off)
                REG_STATUS: begin
                    bus.data_rdata[ST_BUSY]  = tx_busy;
                    bus.data_rdata[ST_FULL]  = fifo_full;
                    bus.data_rdata[ST_EMPTY] = fifo_empty;
                    bus.data_rdata[ST_OVF]   = ovf;
                    bus.data_rdata[ST_CNT_HI:ST_CNT_LO] = 7'(fifo_count);
                end
                REG_BAUD_DIV: begin
                    bus.data_rdata[15:0] = baud_div;
                end
                default: begin
                    bus.data_rdata = '0;
                end
            endcase
        end
    end

endmodule
